riscv_mc_controller: RTL and testbench

Multicycle control unit for the RV32I core's shared-memory datapath. It sequences one instruction over several cycles through fetch, decode, address/execute, memory and writeback. It drives every datapath enable and mux select, and waits on a memory ready handshake. It sits beside the datapath inside `top`, replacing the single-cycle decoder.

---
 rtl/riscv_mc_controller.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_riscv_mc_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mc_controller.sv
// riscv_mc_controller
// Multicycle control unit for the RV32I shared-memory datapath. Sequences one
// instruction through fetch, decode, address/execute, memory and writeback,
// drives every datapath enable and mux select, and stalls on MemReady.
//
// Build option: define RISCV_MC_JALR_EN to add the JALR state. Without it,
// opcode 1100111 is treated as illegal and the unit parks in TRAP.
//
// Reset is asynchronous and active-low. The write enables are also gated
// directly by reset so nothing can be written while it is held.

module riscv_mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] State,
    output logic       Illegal
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_JALR     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    state_t     state_q;
    state_t     state_d;
    logic       illegal_q;

    logic       pc_write_s;
    logic       adr_src_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       reg_write_s;
    logic [1:0] result_src_s;
    logic [1:0] alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] alu_op_s;
    logic [1:0] imm_src_s;
    logic [2:0] alu_control_s;

    // funct3 values the ALU decoder actually implements (add/sub, slt, or, and)
    function automatic logic alu_f3_legal(input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000, 3'b010, 3'b110, 3'b111: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Decode the instruction register into the first post-decode state,
    // rejecting unknown opcodes and unsupported funct3 encodings.
    function automatic state_t decode_next(input logic [6:0] opc, input logic [2:0] f3);
        state_t nxt;
        case (opc)
            OP_LOAD, OP_STORE: nxt = (f3 == 3'b010) ? S_MEMADR : S_TRAP;
            OP_RTYPE:          nxt = alu_f3_legal(f3) ? S_EXECUTER : S_TRAP;
            OP_IALU:           nxt = alu_f3_legal(f3) ? S_EXECUTEI : S_TRAP;
            OP_BRANCH:         nxt = ((f3 == 3'b000) || (f3 == 3'b001)) ? S_BEQ : S_TRAP;
            OP_JAL:            nxt = S_JAL;
`ifdef RISCV_MC_JALR_EN
            OP_JALR:           nxt = (f3 == 3'b000) ? S_JALR : S_TRAP;
`endif
            default:           nxt = S_TRAP;
        endcase
        return nxt;
    endfunction

    // Next-state logic; unknown encodings fall into TRAP so a corrupted
    // state register is flagged rather than silently resumed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (MemReady) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE:   state_d = decode_next(op, funct3);
            S_MEMADR: begin
                if (op[5]) begin
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                if (MemReady) begin
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: begin
                if (MemReady) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEMWRITE;
                end
            end
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_BEQ:      state_d = S_FETCH;
`ifdef RISCV_MC_JALR_EN
            S_JALR:     state_d = S_JAL;
`endif
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
    end

    // State register and sticky illegal flag; reset forces FETCH immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_q | (state_d == S_TRAP);
        end
    end

    // Per-state datapath controls; every signal defaults to 0 (TRAP leaves them so)
    always_comb begin
        pc_write_s   = 1'b0;
        adr_src_s    = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        result_src_s = 2'b00;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b00;
        alu_op_s     = 2'b00;
        case (state_q)
            S_FETCH: begin
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                ir_write_s   = MemReady;
                pc_write_s   = MemReady;
            end
            S_DECODE: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
            end
            S_MEMREAD: begin
                adr_src_s = 1'b1;
            end
            S_MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src_s   = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a_s = 2'b10;
                alu_op_s    = 2'b10;
            end
            S_EXECUTEI: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                alu_op_s    = 2'b10;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
            end
            S_JAL: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b10;
                pc_write_s  = 1'b1;
            end
            S_BEQ: begin
                alu_src_a_s = 2'b10;
                alu_op_s    = 2'b01;
                if (funct3 == 3'b001) begin
                    pc_write_s = ~Zero;
                end else begin
                    pc_write_s = Zero;
                end
            end
`ifdef RISCV_MC_JALR_EN
            S_JALR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
            end
`endif
            default: begin
                pc_write_s = 1'b0;
            end
        endcase
    end

    // ALU decoder: address/PC arithmetic adds, branches subtract, ALU ops use funct3
    always_comb begin
        alu_control_s = 3'b000;
        case (alu_op_s)
            2'b00: alu_control_s = 3'b000;
            2'b01: alu_control_s = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000: begin
                        if (op[5] && funct7b5) begin
                            alu_control_s = 3'b001;
                        end else begin
                            alu_control_s = 3'b000;
                        end
                    end
                    3'b010:  alu_control_s = 3'b101;
                    3'b110:  alu_control_s = 3'b011;
                    3'b111:  alu_control_s = 3'b010;
                    default: alu_control_s = 3'b000;
                endcase
            end
            default: alu_control_s = 3'b000;
        endcase
    end

    // Immediate format selection straight from the opcode
    always_comb begin
        imm_src_s = 2'b00;
        case (op)
            OP_STORE:  imm_src_s = 2'b01;
            OP_BRANCH: imm_src_s = 2'b10;
            OP_JAL:    imm_src_s = 2'b11;
            default:   imm_src_s = 2'b00;
        endcase
    end

    assign PCWrite    = pc_write_s  & reset;
    assign IRWrite    = ir_write_s  & reset;
    assign MemWrite   = mem_write_s & reset;
    assign RegWrite   = reg_write_s & reset;
    assign AdrSrc     = adr_src_s;
    assign ResultSrc  = result_src_s;
    assign ALUSrcA    = alu_src_a_s;
    assign ALUSrcB    = alu_src_b_s;
    assign ImmSrc     = imm_src_s;
    assign ALUControl = alu_control_s;
    assign State      = state_q;
    assign Illegal    = illegal_q;

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Self-checking bench for riscv_mc_controller. Each instruction is expanded
// into the list of states it must visit (with MemReady stalls), and every
// cycle the full output bundle is compared with the per-state output table.
// Honours RISCV_MC_JALR_EN the same way as the design.

module tb_riscv_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;
    logic       Illegal;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RT   = 7'b0110011;
    localparam logic [6:0] IA   = 7'b0010011;
    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] JL   = 7'b1101111;
    localparam logic [6:0] JR   = 7'b1100111;

    riscv_mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .State      (State),
        .Illegal    (Illegal)
    );

    always #5 clk = ~clk;

    // Expected outputs from the per-state control table
    function automatic logic [20:0] expect_out(input int st, input logic rst_n, input logic mr,
                                               input logic z, input logic [6:0] o,
                                               input logic [2:0] f3, input logic f7);
        logic pcw, adr, mw, irw, rw, ill;
        logic [1:0] rs, sa, sb, imm;
        int aluop;
        logic [2:0] ac;
        logic [3:0] st4;
        pcw = 1'b0; adr = 1'b0; mw = 1'b0; irw = 1'b0; rw = 1'b0;
        rs = 2'b00; sa = 2'b00; sb = 2'b00; aluop = 0;
        case (st)
            0:  begin sb = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
            1:  begin sa = 2'b01; sb = 2'b01; end
            2:  begin sa = 2'b10; sb = 2'b01; end
            3:  adr = 1'b1;
            4:  begin rs = 2'b01; rw = 1'b1; end
            5:  begin adr = 1'b1; mw = 1'b1; end
            6:  begin sa = 2'b10; aluop = 2; end
            7:  rw = 1'b1;
            8:  begin sa = 2'b10; sb = 2'b01; aluop = 2; end
            9:  begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
            10: begin sa = 2'b10; aluop = 1; pcw = (f3 == 3'b000) ? z : ~z; end
            11: begin sa = 2'b10; sb = 2'b01; end
            default: ;
        endcase
        if (o == SW) imm = 2'b01;
        else if (o == BR) imm = 2'b10;
        else if (o == JL) imm = 2'b11;
        else imm = 2'b00;
        ac = 3'b000;
        if (aluop == 1) ac = 3'b001;
        if (aluop == 2) begin
            if (f3 == 3'd0) ac = (o[5] && f7) ? 3'b001 : 3'b000;
            else if (f3 == 3'd2) ac = 3'b101;
            else if (f3 == 3'd6) ac = 3'b011;
            else if (f3 == 3'd7) ac = 3'b010;
        end
        if (!rst_n) begin pcw = 1'b0; irw = 1'b0; mw = 1'b0; rw = 1'b0; end
        st4 = 4'(st);
        ill = (st == 12);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, ac, st4, ill};
    endfunction

    task automatic check(input string tag, input int st, input logic mr, input logic z);
        logic [20:0] exp_v;
        logic [20:0] obs_v;
        exp_v = expect_out(st, reset, mr, z, op, funct3, funct7b5);
        obs_v = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                 ALUSrcB, ImmSrc, ALUControl, State, Illegal};
        n_checks++;
        assert (obs_v === exp_v) else begin
            n_fail++;
            $error("FAIL %s: state exp %0d observed %h expected %h", tag, st, obs_v, exp_v);
        end
    endtask

    // Drive one cycle per entry, compare at the falling edge
    task automatic run_seq(input string tag, input int sts[$], input logic mrs[$], input logic z);
        for (int i = 0; i < sts.size(); i++) begin
            MemReady = mrs[i];
            Zero     = z;
            @(negedge clk);
            check(tag, sts[i], mrs[i], z);
            @(posedge clk);
            #1;
        end
    endtask

    // Hold reset for some cycles (all enables must stay low), then release
    task automatic do_reset(input int cycles);
        reset = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            MemReady = 1'b1;
            @(negedge clk);
            check("reset", 0, 1'b1, Zero);
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
    endtask

    // Build the expected state walk of one instruction from its class and run it
    task automatic exec_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                              input logic f7, input logic z, input int fs, input int ms,
                              input int trap_cycles);
        int   sts[$];
        logic mrs[$];
        bit   trap;
        bit   alu_ok;
        op = o; funct3 = f3; funct7b5 = f7;
        alu_ok = (f3 == 3'd0) || (f3 == 3'd2) || (f3 == 3'd6) || (f3 == 3'd7);
        trap = 1'b0;
        repeat (fs) begin sts.push_back(0); mrs.push_back(1'b0); end
        sts.push_back(0); mrs.push_back(1'b1);
        sts.push_back(1); mrs.push_back(1'($urandom_range(0, 1)));
        if ((o == LW || o == SW) && f3 == 3'd2) begin
            sts.push_back(2); mrs.push_back(1'($urandom_range(0, 1)));
            repeat (ms) begin sts.push_back(o == LW ? 3 : 5); mrs.push_back(1'b0); end
            sts.push_back(o == LW ? 3 : 5); mrs.push_back(1'b1);
            if (o == LW) begin sts.push_back(4); mrs.push_back(1'($urandom_range(0, 1))); end
        end else if ((o == RT || o == IA) && alu_ok) begin
            sts.push_back(o == RT ? 6 : 8); mrs.push_back(1'($urandom_range(0, 1)));
            sts.push_back(7); mrs.push_back(1'($urandom_range(0, 1)));
        end else if (o == BR && f3 <= 3'd1) begin
            sts.push_back(10); mrs.push_back(1'($urandom_range(0, 1)));
        end else if (o == JL) begin
            sts.push_back(9); mrs.push_back(1'($urandom_range(0, 1)));
            sts.push_back(7); mrs.push_back(1'($urandom_range(0, 1)));
`ifdef RISCV_MC_JALR_EN
        end else if (o == JR && f3 == 3'd0) begin
            sts.push_back(11); mrs.push_back(1'($urandom_range(0, 1)));
            sts.push_back(9);  mrs.push_back(1'($urandom_range(0, 1)));
            sts.push_back(7);  mrs.push_back(1'($urandom_range(0, 1)));
`endif
        end else begin
            trap = 1'b1;
            repeat (trap_cycles) begin sts.push_back(12); mrs.push_back(1'($urandom_range(0, 1))); end
        end
        run_seq(tag, sts, mrs, z);
        if (trap) do_reset(1);
    endtask

    initial begin
        logic [6:0] ops[8];
        int         alu_f3[4];
        int         sts[$];
        logic       mrs[$];
        logic [6:0] o;
        logic [2:0] f3;
        ops    = '{LW, SW, RT, IA, BR, JL, JR, 7'b0000000};
        alu_f3 = '{0, 2, 6, 7};
        reset = 1'b0; op = LW; funct3 = 3'd2; funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b1;
        #1;
        do_reset(3);

        exec_instr("lw",        LW, 3'd2, 1'b0, 1'b0, 0, 0, 0);
        exec_instr("sw_stall",  SW, 3'd2, 1'b0, 1'b0, 0, 3, 0);
        exec_instr("beq_taken", BR, 3'd0, 1'b0, 1'b1, 0, 0, 0);
        exec_instr("beq_not",   BR, 3'd0, 1'b0, 1'b0, 0, 0, 0);
        exec_instr("bne_taken", BR, 3'd1, 1'b0, 1'b0, 0, 0, 0);
        exec_instr("sub",       RT, 3'd0, 1'b1, 1'b0, 0, 0, 0);
        exec_instr("addi_f7",   IA, 3'd0, 1'b1, 1'b0, 0, 0, 0);
        exec_instr("slt",       RT, 3'd2, 1'b0, 1'b0, 0, 0, 0);
        exec_instr("fetch_stl", JL, 3'd0, 1'b0, 1'b0, 2, 0, 0);
        exec_instr("lw_stall",  LW, 3'd2, 1'b0, 1'b0, 1, 2, 0);
        exec_instr("illegal",   7'b1111111, 3'd0, 1'b0, 1'b0, 0, 0, 11);
        exec_instr("jalr",      JR, 3'd0, 1'b0, 1'b0, 0, 0, 3);
        exec_instr("lw_badf3",  LW, 3'd0, 1'b0, 1'b0, 0, 0, 2);
        exec_instr("br_badf3",  BR, 3'd4, 1'b0, 1'b0, 0, 0, 2);

        for (int k = 0; k < 60; k++) begin
            o = ops[$urandom_range(0, 7)];
            if (o == 7'b0000000) o = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
            else if (o == LW || o == SW) f3 = 3'd2;
            else if (o == BR) f3 = 3'($urandom_range(0, 1));
            else if (o == JR) f3 = 3'd0;
            else f3 = 3'(alu_f3[$urandom_range(0, 3)]);
            exec_instr("random", o, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 3), $urandom_range(0, 3), 2);
        end

        // Reset arriving in MEMWB must suppress the register write at once
        op = LW; funct3 = 3'd2; funct7b5 = 1'b0;
        sts = '{0, 1, 2, 3};
        mrs = '{1'b1, 1'b1, 1'b1, 1'b1};
        run_seq("lw_abort", sts, mrs, 1'b0);
        do_reset(2);
        exec_instr("post_abort", RT, 3'd7, 1'b0, 1'b0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
